// File: rtl/complex_issue_queue.sv
// rtl/complex_issue_queue.sv - age-ordered compacting issue queue for the complex FU
// Oldest-first select, wakeup by preg match, single issue per cycle, flush clears all.
`ifndef PREG_INDEX_WIDTH
`define PREG_INDEX_WIDTH 6
`endif

package complex_issue_queue_pkg;
  localparam int PREG_INDEX_WIDTH = `PREG_INDEX_WIDTH;
  localparam int ROB_INDEX_WIDTH  = 5;

  typedef struct packed {
    logic [PREG_INDEX_WIDTH-1:0] issued_preg_rj;
    logic [PREG_INDEX_WIDTH-1:0] issued_preg_rk;
    logic [PREG_INDEX_WIDTH-1:0] issued_preg_rd;
    logic [ROB_INDEX_WIDTH-1:0]  rob;
    logic [3:0]                  gen_op_type;
    logic [3:0]                  spec_op_type;
  } complex_issue_queue_issued_info_t;
endpackage

module complex_issue_queue
  import complex_issue_queue_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int WB_PORTS = 2
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        disp_valid,
  input  complex_issue_queue_issued_info_t            disp_info,
  input  logic                                        disp_rj_ready,
  input  logic                                        disp_rk_ready,
  output logic                                        disp_ready,
  input  logic [WB_PORTS-1:0]                         wb_valid,
  input  logic [WB_PORTS-1:0][PREG_INDEX_WIDTH-1:0]   wb_preg,
  input  logic                                        flush,
  output complex_issue_queue_issued_info_t            issued_info,
  output logic                                        issue_valid,
  input  logic                                        fu_ready,
  output logic [$clog2(DEPTH+1)-1:0]                  iq_count
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int IW = $clog2(DEPTH);

  typedef struct packed {
    logic                             valid;
    logic                             rj_rdy;
    logic                             rk_rdy;
    complex_issue_queue_issued_info_t info;
  } entry_t;

  entry_t        ent_q [DEPTH];
  entry_t        ent_d [DEPTH];
  entry_t        woke  [DEPTH];
  entry_t        upper [DEPTH];
  logic          sel_found;
  logic [IW-1:0] sel_idx;
  logic          issue_fire;
  logic          disp_fire;
  logic [CW-1:0] disp_slot;
  logic [CW-1:0] count_d;

  function automatic logic woken(input logic [PREG_INDEX_WIDTH-1:0] preg,
                                 input logic [WB_PORTS-1:0] v,
                                 input logic [WB_PORTS-1:0][PREG_INDEX_WIDTH-1:0] p);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < WB_PORTS; k++) begin
      if (v[k] && (p[k] == preg)) hit = 1'b1;
    end
    return hit;
  endfunction

  // Selection looks only at registered ready bits, so a wakeup never bypasses to issue.
  always_comb begin
    sel_found   = 1'b0;
    sel_idx     = '0;
    issued_info = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!sel_found && ent_q[i].valid && ent_q[i].rj_rdy && ent_q[i].rk_rdy) begin
        sel_found   = 1'b1;
        sel_idx     = IW'(i);
        issued_info = ent_q[i].info;
      end
    end
  end

  assign issue_valid = sel_found && !flush;
  assign issue_fire  = issue_valid && fu_ready;
  assign disp_ready  = (iq_count < CW'(DEPTH));
  assign disp_fire   = disp_valid && disp_ready && !flush;
  assign disp_slot   = iq_count - CW'(issue_fire);

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      woke[i]        = ent_q[i];
      woke[i].rj_rdy = ent_q[i].rj_rdy | woken(ent_q[i].info.issued_preg_rj, wb_valid, wb_preg);
      woke[i].rk_rdy = ent_q[i].rk_rdy | woken(ent_q[i].info.issued_preg_rk, wb_valid, wb_preg);
      upper[i]       = '0;
    end
    for (int i = 0; i < DEPTH-1; i++) begin
      upper[i] = woke[i+1];
    end
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = (issue_fire && (IW'(i) >= sel_idx)) ? upper[i] : woke[i];
      if (disp_fire && (CW'(i) == disp_slot)) begin
        ent_d[i].valid  = 1'b1;
        ent_d[i].info   = disp_info;
        ent_d[i].rj_rdy = disp_rj_ready | woken(disp_info.issued_preg_rj, wb_valid, wb_preg);
        ent_d[i].rk_rdy = disp_rk_ready | woken(disp_info.issued_preg_rk, wb_valid, wb_preg);
      end
      if (flush) ent_d[i].valid = 1'b0;
    end
    count_d = flush ? '0 : (iq_count + CW'(disp_fire) - CW'(issue_fire));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      iq_count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
      iq_count <= count_d;
    end
  end
endmodule

// File: tb/tb_complex_issue_queue.sv
// tb/tb_complex_issue_queue.sv - scoreboard bench for complex_issue_queue
// Queue-of-entries reference model feeds expectations; a negedge monitor compares.
module tb_complex_issue_queue;
  import complex_issue_queue_pkg::*;
  localparam int DEPTH = 4;
  localparam int WB    = 2;
  localparam int PW    = PREG_INDEX_WIDTH;
  localparam int CW    = $clog2(DEPTH+1);
  typedef complex_issue_queue_issued_info_t info_t;

  logic                 clk, rst, disp_valid, disp_rj_ready, disp_rk_ready, disp_ready;
  info_t                disp_info, issued_info;
  logic [WB-1:0]        wb_valid;
  logic [WB-1:0][PW-1:0] wb_preg;
  logic                 flush, issue_valid, fu_ready;
  logic [CW-1:0]        iq_count;

  complex_issue_queue #(.DEPTH(DEPTH), .WB_PORTS(WB)) dut (
    .clk(clk), .rst(rst), .disp_valid(disp_valid), .disp_info(disp_info),
    .disp_rj_ready(disp_rj_ready), .disp_rk_ready(disp_rk_ready), .disp_ready(disp_ready),
    .wb_valid(wb_valid), .wb_preg(wb_preg), .flush(flush), .issued_info(issued_info),
    .issue_valid(issue_valid), .fu_ready(fu_ready), .iq_count(iq_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { info_t info; bit rj; bit rk; } ment_t;
  typedef struct { logic iv; info_t info; int cnt; logic dr; } cyc_t;
  ment_t mq[$];
  cyc_t  cyc_q[$];
  info_t iss_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic bit hit(input logic [PW-1:0] p, input logic [WB-1:0] wv,
                             input logic [WB-1:0][PW-1:0] wp);
    bit h = 0;
    for (int k = 0; k < WB; k++) if (wv[k] && wp[k] == p) h = 1;
    return h;
  endfunction

  function automatic info_t mk(input int rob, input int rj, input int rk);
    info_t t;
    t.issued_preg_rj = PW'(rj);
    t.issued_preg_rk = PW'(rk);
    t.issued_preg_rd = PW'($urandom_range(0, 63));
    t.rob            = ROB_INDEX_WIDTH'(rob);
    t.gen_op_type    = 4'($urandom_range(0, 15));
    t.spec_op_type   = 4'($urandom_range(0, 15));
    return t;
  endfunction

  task automatic step(input logic dv, input info_t di, input logic rjr, input logic rkr,
                      input logic [WB-1:0] wv, input logic [WB-1:0][PW-1:0] wp,
                      input logic fl, input logic fr);
    cyc_t  c;
    ment_t n;
    int    sel;
    bit    acc;
    disp_valid = dv; disp_info = di; disp_rj_ready = rjr; disp_rk_ready = rkr;
    wb_valid = wv; wb_preg = wp; flush = fl; fu_ready = fr;
    sel = -1;
    foreach (mq[i]) if (sel < 0 && mq[i].rj && mq[i].rk) sel = i;
    c.iv   = (sel >= 0) && !fl;
    c.info = '0;
    if (sel >= 0) c.info = mq[sel].info;
    c.cnt  = mq.size();
    c.dr   = (mq.size() < DEPTH);
    cyc_q.push_back(c);
    if (c.iv && fr) iss_q.push_back(mq[sel].info);
    if (fl) begin
      mq.delete();
    end else begin
      acc = dv && (mq.size() < DEPTH);
      foreach (mq[i]) begin
        mq[i].rj = mq[i].rj | hit(mq[i].info.issued_preg_rj, wv, wp);
        mq[i].rk = mq[i].rk | hit(mq[i].info.issued_preg_rk, wv, wp);
      end
      if (c.iv && fr) mq.delete(sel);
      if (acc) begin
        n.info = di;
        n.rj   = rjr || hit(di.issued_preg_rj, wv, wp);
        n.rk   = rkr || hit(di.issued_preg_rk, wv, wp);
        mq.push_back(n);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic fr);
    step(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, fr);
  endtask

  always @(negedge clk) begin
    cyc_t  c;
    info_t e;
    if (!rst && cyc_q.size() > 0) begin
      c = cyc_q.pop_front();
      check("issue_valid", issue_valid, c.iv);
      check("issued_info", issued_info, c.info);
      check("iq_count", iq_count, c.cnt);
      check("disp_ready", disp_ready, c.dr);
      if (issue_valid && fu_ready) begin
        checks++;
        if (iss_q.size() == 0) begin
          errors++;
          $display("FAIL issue_handshake actual=rob%0d expected=no_issue", issued_info.rob);
        end else begin
          e = iss_q.pop_front();
          if (issued_info !== e) begin
            errors++;
            $display("FAIL issue_payload actual=%0h expected=%0h", issued_info, e);
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1; disp_valid = 0; disp_info = '0; disp_rj_ready = 0; disp_rk_ready = 0;
    wb_valid = '0; wb_preg = '0; flush = 0; fu_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_iq_count", iq_count, 0);
    check("rst_issue_valid", issue_valid, 0);
    check("rst_issued_info", issued_info, 0);
    check("rst_disp_ready", disp_ready, 1);
    rst = 1'b0;

    // A issues the cycle after dispatch
    step(1, mk(3, 1, 2), 1, 1, '0, '0, 0, 1);
    check("a_issue_valid", issue_valid, 1);
    check("a_rob", issued_info.rob, 3);
    idle(1); idle(1);

    // B waits on preg 12, younger C overtakes it
    step(1, mk(4, 12, 13), 0, 1, '0, '0, 0, 1);
    step(1, mk(5, 1, 2), 1, 1, '0, '0, 0, 1);
    idle(1); idle(1);
    step(0, '0, 0, 0, 2'b01, {PW'(0), PW'(12)}, 0, 1);
    idle(1); idle(1);

    // full queue with FU stalled, extra dispatches ignored
    for (int k = 0; k < 4; k++) step(1, mk(8 + k, k, k + 1), 1, 1, '0, '0, 0, 0);
    repeat (3) step(1, mk(20, 1, 1), 1, 1, '0, '0, 0, 0);
    repeat (5) idle(1);

    // simultaneous issue and dispatch at count 2
    step(1, mk(1, 2, 3), 1, 1, '0, '0, 0, 0);
    step(1, mk(2, 2, 3), 1, 1, '0, '0, 0, 0);
    step(1, mk(6, 2, 3), 1, 1, '0, '0, 0, 1);
    repeat (3) idle(1);

    // flush beats dispatch and issue
    step(1, mk(13, 2, 3), 1, 1, '0, '0, 0, 0);
    step(1, mk(14, 2, 3), 1, 1, '0, '0, 0, 0);
    step(1, mk(9, 2, 3), 1, 1, '0, '0, 1, 1);
    idle(0); idle(1);

    // same-cycle wakeup of a dispatched source on port 1
    step(1, mk(11, 3, 7), 1, 0, 2'b10, {PW'(7), PW'(0)}, 0, 0);
    idle(1); idle(1);

    // reset mid-operation, asserted between edges
    for (int k = 0; k < 3; k++) step(1, mk(16 + k, 1, 30 + k), 1, 0, '0, '0, 0, 0);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_iq_count", iq_count, 0);
    check("mid_rst_issue_valid", issue_valid, 0);
    check("mid_rst_issued_info", issued_info, 0);
    check("mid_rst_disp_ready", disp_ready, 1);
    mq.delete(); cyc_q.delete(); iss_q.delete();
    @(posedge clk);
    #1;
    check("rst_hold_iq_count", iq_count, 0);
    rst = 1'b0;
    step(1, mk(21, 1, 2), 1, 1, '0, '0, 0, 0);
    idle(1); idle(1);

    // randomized traffic
    repeat (400) begin
      logic [WB-1:0]         wv;
      logic [WB-1:0][PW-1:0] wp;
      wv = WB'($urandom_range(0, (1 << WB) - 1));
      for (int k = 0; k < WB; k++) wp[k] = PW'($urandom_range(0, 15));
      step($urandom_range(0, 9) < 6,
           mk($urandom_range(0, 31), $urandom_range(0, 15), $urandom_range(0, 15)),
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, wv, wp,
           $urandom_range(0, 39) == 0, $urandom_range(0, 9) < 7);
    end
    step(0, '0, 0, 0, '0, '0, 1, 1);
    idle(1);

    checks++;
    if (iss_q.size() != 0) begin
      errors++;
      $display("FAIL pending_issues actual=%0d expected=0", iss_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/complex_issue_queue.md
COMPLEX_ISSUE_QUEUE -- requirements
Module: complex_issue_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4: number of queue entries (2..8).
REQ-002 SHALL have parameter WB_PORTS, default 2: number of wakeup broadcast ports.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port disp_valid, input, 1 bit: dispatch request.
REQ-006 SHALL have port disp_info, input, complex_issue_queue_issued_info_t: dispatched instruction; issued_preg_rj/rk/rd, rob index, gen/spec op type.
REQ-007 SHALL have ports disp_rj_ready and disp_rk_ready, input, 1 bit each: source already available at dispatch.
REQ-008 SHALL have port disp_ready, output, 1 bit: queue can accept a dispatch this cycle.
REQ-009 SHALL have port wb_valid, input, WB_PORTS bits: wakeup strobes.
REQ-010 SHALL have port wb_preg, input, WB_PORTS x `PREG_INDEX_WIDTH: woken physical registers.
REQ-011 SHALL have port flush, input, 1 bit: discard all entries.
REQ-012 SHALL have port issued_info, output, complex_issue_queue_issued_info_t: selected entry's payload.
REQ-013 SHALL have port issue_valid, output, 1 bit: issued_info is valid this cycle.
REQ-014 SHALL have port fu_ready, input, 1 bit: complex FU accepts an issue this cycle.
REQ-015 SHALL have port iq_count, output, $clog2(DEPTH+1) bits: occupied entries.

Function
REQ-016 SHALL keep entries age-ordered and compacting: entry 0 oldest; each entry holds valid, payload, rj_rdy, rk_rdy.
REQ-017 SHALL drive disp_ready = (iq_count < DEPTH), computed from registered count only; an issue in the same cycle does not free space.
REQ-018 SHALL write a dispatch (disp_valid && disp_ready) into the first free slot after compaction, and the entry SHALL be valid from the next cycle.
REQ-019 SHALL ignore disp_valid when disp_ready=0; no state change, no payload corruption.
REQ-020 SHALL set an entry's rj_rdy/rk_rdy at the edge when any wb_valid[p] has wb_preg[p] equal to that source index.
REQ-021 SHALL treat a dispatched source as ready if its disp_*_ready is 1 or a same-cycle wakeup matches it.
REQ-022 SHALL make wakeup effective for selection the cycle after the strobe; there is no same-cycle wakeup-to-issue bypass.
REQ-023 SHALL select combinationally the lowest-index valid entry with rj_rdy && rk_rdy.
REQ-024 SHALL drive issue_valid = a selected entry exists && !flush; issued_info shows the selected entry's payload, and all-zero when none is selected.
REQ-025 SHALL treat the handshake as: removal occurs at the edge where issue_valid && fu_ready; if fu_ready=0, the entry stays and is re-presented.
REQ-026 SHALL shift entries above a removed entry down by one in the same edge, preserving order and ready bits, including wakeups arriving that cycle.
REQ-027 SHALL handle issue and dispatch in the same cycle: both take effect; the new entry lands at index count-1, or count if no issue.
REQ-028 SHALL give flush priority over dispatch, issue and wakeup: at the edge, all valid bits clear and count becomes 0.
REQ-029 SHALL keep iq_count = registered count; next = count + dispatch - issue, and 0 on flush.
REQ-030 SHALL issue at most one entry per cycle.

Reset
REQ-031 SHALL, while rst=1, immediately clear all entry valid bits and hold iq_count=0, issue_valid=0, issued_info=0 and disp_ready=1, independent of clk.
REQ-032 SHALL, on reset asserted mid-operation, lose all queued entries; after deassertion, the first dispatch lands in entry 0.

Verification
REQ-033 SHALL be tested as: reset, dispatch A (rob 3, rj/rk ready) -> next cycle issue_valid=1, issued_info.rob=3; fu_ready=1 -> iq_count 1->0.
REQ-034 SHALL be tested as: dispatch B (rj=preg 12, not ready), then C (ready) -> C issues first; wb_preg=12 in cycle t -> B issue_valid at t+1.
REQ-035 SHALL be tested as: fill 4 entries with ready sources, fu_ready=0 for 3 cycles -> disp_ready=0, issue_valid=1 on oldest each cycle, extra dispatch ignored, count stays 4.
REQ-036 SHALL be tested as: count=2 (both ready), same-cycle issue + dispatch -> count stays 2 and the order is old-second, then new.
REQ-037 SHALL be tested as: flush with disp_valid=1 and issue-eligible entries -> issue_valid=0 that cycle, count=0 next, and the dispatch is dropped.
REQ-038 SHALL be tested as: dispatch with rk=preg 7 not ready while wb_preg[1]=7 in the same cycle -> entry issue-eligible the next cycle.
